// File: rtl/status_reg_stack.sv
// Status/flag register with a LIFO shadow stack for interrupt entry/return.
// Holds forced bits, zero/negative derivation, sticky overflow/underflow errors.
module status_reg_stack #(
    parameter int                WIDTH         = 8,
    parameter int                DEPTH         = 4,
    parameter logic [WIDTH-1:0]  FIXED_MASK    = WIDTH'(8'h30),
    parameter logic [WIDTH-1:0]  FIXED_VAL     = WIDTH'(8'h20),
    parameter logic [WIDTH-1:0]  AUTO_SET_MASK = WIDTH'(8'h04),
    parameter int                BRK_BIT       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               upd_mask,
    input  logic [WIDTH-1:0]               upd_val,
    input  logic                           zn_en,
    input  logic [WIDTH-1:0]               db_in,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           err_clr,
    input  logic                           brk_inject,
    output logic [WIDTH-1:0]               flags_q,
    output logic [WIDTH-1:0]               flags_out,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           full,
    output logic                           empty,
    output logic                           ovf_err,
    output logic                           unf_err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [WIDTH-1:0] live_q;
    logic [WIDTH-1:0] live_d;
    logic [WIDTH-1:0] top_entry;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic             ovf_q;
    logic             unf_q;

    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             do_restore;
    logic             ovf_set;
    logic             unf_set;

    assign is_full  = (depth_q == DW'(DEPTH));
    assign is_empty = (depth_q == '0);

    // Index arithmetic is only consumed when the corresponding slot is valid.
    assign top_idx   = AW'(depth_q - DW'(1));
    assign push_idx  = AW'(depth_q);
    assign top_entry = stack_mem[top_idx];

    // Push+pop on an empty stack degenerates to a plain push; on a non-empty
    // stack it swaps the live register with the top entry.
    assign do_push    = push & ~is_full & (~pop | is_empty);
    assign do_pop     = pop & ~push & ~is_empty;
    assign do_swap    = push & pop & ~is_empty;
    assign do_restore = do_pop | do_swap;
    assign ovf_set    = push & ~pop & is_full;
    assign unf_set    = pop & ~push & is_empty;

    always_comb begin
        live_d = live_q;
        if (do_restore) begin
            live_d = top_entry;
        end else begin
            if (zn_en) begin
                live_d[1]       = ~|db_in;
                live_d[WIDTH-1] = db_in[WIDTH-1];
            end
            live_d = (live_d & ~upd_mask) | (upd_val & upd_mask);
            if (do_push) begin
                live_d = live_d | AUTO_SET_MASK;
            end
        end
        live_d = (live_d & ~FIXED_MASK) | (FIXED_VAL & FIXED_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q  <= FIXED_VAL & FIXED_MASK;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            live_q <= live_d;
            if (do_push) begin
                depth_q <= depth_q + DW'(1);
            end else if (do_pop) begin
                depth_q <= depth_q - DW'(1);
            end
            // A new error in the same cycle as a clear must survive it.
            ovf_q <= (ovf_q & ~err_clr) | ovf_set;
            unf_q <= (unf_q & ~err_clr) | unf_set;
        end
    end

    // Stack storage needs no reset; reset empties it by clearing depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push) begin
                stack_mem[push_idx] <= live_q;
            end else if (do_swap) begin
                stack_mem[top_idx] <= live_q;
            end
        end
    end

    always_comb begin
        flags_out          = live_q;
        flags_out[BRK_BIT] = brk_inject;
    end

    assign flags_q = live_q;
    assign depth   = depth_q;
    assign full    = is_full;
    assign empty   = is_empty;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed self-checking bench for status_reg_stack at default parameters.
module tb_status_reg_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] upd_mask;
    logic [7:0] upd_val;
    logic       zn_en;
    logic [7:0] db_in;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic       brk_inject;
    logic [7:0] flags_q;
    logic [7:0] flags_out;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;

    int checks = 0;
    int passed = 0;

    status_reg_stack dut (
        .clk        (clk),
        .rst        (rst),
        .upd_mask   (upd_mask),
        .upd_val    (upd_val),
        .zn_en      (zn_en),
        .db_in      (db_in),
        .push       (push),
        .pop        (pop),
        .err_clr    (err_clr),
        .brk_inject (brk_inject),
        .flags_q    (flags_q),
        .flags_out  (flags_out),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst = 1'b0; upd_mask = 8'h00; upd_val = 8'h00; zn_en = 1'b0; db_in = 8'h00;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; brk_inject = 1'b0;
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; push = 1'b1;
        tick();
        checks++; if (flags_q !== 8'h20) $display("[TB] FAIL reset_flags got %h exp %h", flags_q, 8'h20); else passed++;
        checks++; if (depth !== 3'd0) $display("[TB] FAIL reset_depth got %0d exp 0", depth); else passed++;
        checks++; if (empty !== 1'b1 || full !== 1'b0) $display("[TB] FAIL reset_empty_full got %b%b exp 10", empty, full); else passed++;
        checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) $display("[TB] FAIL reset_errors got %b%b exp 00", ovf_err, unf_err); else passed++;
        brk_inject = 1'b1; #1;
        checks++; if (flags_out !== 8'h30) $display("[TB] FAIL brk_on got %h exp %h", flags_out, 8'h30); else passed++;
        brk_inject = 1'b0; #1;
        checks++; if (flags_out !== 8'h20) $display("[TB] FAIL brk_off got %h exp %h", flags_out, 8'h20); else passed++;
    endtask

    task automatic test_update_zn();
        zn_en = 1'b1; db_in = 8'h00;
        tick();
        checks++; if (flags_q !== 8'h22) $display("[TB] FAIL zn_zero got %h exp %h", flags_q, 8'h22); else passed++;
        zn_en = 1'b1; db_in = 8'h80;
        tick();
        checks++; if (flags_q !== 8'hA0) $display("[TB] FAIL zn_neg got %h exp %h", flags_q, 8'hA0); else passed++;
        zn_en = 1'b1; db_in = 8'h80; upd_mask = 8'h80; upd_val = 8'h00;
        tick();
        checks++; if (flags_q !== 8'h20) $display("[TB] FAIL upd_over_zn got %h exp %h", flags_q, 8'h20); else passed++;
        upd_mask = 8'hFF; upd_val = 8'hFF;
        tick();
        checks++; if (flags_q !== 8'hEF) $display("[TB] FAIL fixed_bits got %h exp %h", flags_q, 8'hEF); else passed++;
        upd_mask = 8'hFF; upd_val = 8'h21;
        tick();
        checks++; if (flags_q !== 8'h21) $display("[TB] FAIL upd_set got %h exp %h", flags_q, 8'h21); else passed++;
    endtask

    task automatic test_push_pop();
        push = 1'b1;
        tick();
        checks++; if (flags_q !== 8'h25) $display("[TB] FAIL push_auto got %h exp %h", flags_q, 8'h25); else passed++;
        checks++; if (depth !== 3'd1 || empty !== 1'b0) $display("[TB] FAIL push_depth got %0d/%b exp 1/0", depth, empty); else passed++;
        upd_mask = 8'h01; upd_val = 8'h00;
        tick();
        checks++; if (flags_q !== 8'h24) $display("[TB] FAIL push_upd got %h exp %h", flags_q, 8'h24); else passed++;
        pop = 1'b1; upd_mask = 8'h80; upd_val = 8'h80; zn_en = 1'b1; db_in = 8'h00;
        tick();
        checks++; if (flags_q !== 8'h21) $display("[TB] FAIL pop_restore got %h exp %h", flags_q, 8'h21); else passed++;
        checks++; if (depth !== 3'd0 || empty !== 1'b1) $display("[TB] FAIL pop_depth got %0d/%b exp 0/1", depth, empty); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] upd_tab [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
        logic [7:0] live_tab [4] = '{8'h64, 8'hA4, 8'h25, 8'h26};
        logic [7:0] pop_tab [4] = '{8'h25, 8'hA4, 8'h64, 8'h21};
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; upd_mask = 8'hC3; upd_val = upd_tab[i];
            tick();
            checks++; if (flags_q !== live_tab[i] || depth !== 3'(i + 1)) $display("[TB] FAIL ovf_push%0d got %h/%0d exp %h/%0d", i, flags_q, depth, live_tab[i], i + 1); else passed++;
        end
        checks++; if (full !== 1'b1 || ovf_err !== 1'b0) $display("[TB] FAIL full_flag got %b/%b exp 1/0", full, ovf_err); else passed++;
        push = 1'b1; upd_mask = 8'h04; upd_val = 8'h00;
        tick();
        checks++; if (flags_q !== 8'h22) $display("[TB] FAIL ovf_live got %h exp %h", flags_q, 8'h22); else passed++;
        checks++; if (ovf_err !== 1'b1 || depth !== 3'd4 || full !== 1'b1) $display("[TB] FAIL ovf_set got %b/%0d/%b exp 1/4/1", ovf_err, depth, full); else passed++;
        push = 1'b1; err_clr = 1'b1;
        tick();
        checks++; if (ovf_err !== 1'b1) $display("[TB] FAIL ovf_set_wins got %b exp 1", ovf_err); else passed++;
        err_clr = 1'b1;
        tick();
        checks++; if (ovf_err !== 1'b0) $display("[TB] FAIL ovf_clr got %b exp 0", ovf_err); else passed++;
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            tick();
            checks++; if (flags_q !== pop_tab[i] || depth !== 3'(3 - i)) $display("[TB] FAIL ovf_pop%0d got %h/%0d exp %h/%0d", i, flags_q, depth, pop_tab[i], 3 - i); else passed++;
        end
    endtask

    task automatic test_underflow_swap();
        pop = 1'b1;
        tick();
        checks++; if (flags_q !== 8'h21 || unf_err !== 1'b1) $display("[TB] FAIL unf_set got %h/%b exp 21/1", flags_q, unf_err); else passed++;
        pop = 1'b1; upd_mask = 8'h80; upd_val = 8'h80;
        tick();
        checks++; if (flags_q !== 8'hA1 || depth !== 3'd0) $display("[TB] FAIL unf_live got %h/%0d exp a1/0", flags_q, depth); else passed++;
        err_clr = 1'b1; upd_mask = 8'h80; upd_val = 8'h00;
        tick();
        checks++; if (unf_err !== 1'b0 || flags_q !== 8'h21) $display("[TB] FAIL unf_clr got %b/%h exp 0/21", unf_err, flags_q); else passed++;
        push = 1'b1;
        tick();
        upd_mask = 8'hFF; upd_val = 8'hE0;
        tick();
        checks++; if (flags_q !== 8'hE0 || depth !== 3'd1) $display("[TB] FAIL swap_setup got %h/%0d exp e0/1", flags_q, depth); else passed++;
        push = 1'b1; pop = 1'b1;
        tick();
        checks++; if (flags_q !== 8'h21 || depth !== 3'd1) $display("[TB] FAIL swap got %h/%0d exp 21/1", flags_q, depth); else passed++;
        checks++; if (unf_err !== 1'b0 || ovf_err !== 1'b0) $display("[TB] FAIL swap_err got %b%b exp 00", ovf_err, unf_err); else passed++;
        pop = 1'b1;
        tick();
        checks++; if (flags_q !== 8'hE0 || depth !== 3'd0) $display("[TB] FAIL swap_top got %h/%0d exp e0/0", flags_q, depth); else passed++;
        push = 1'b1; pop = 1'b1;
        tick();
        checks++; if (flags_q !== 8'hE4 || depth !== 3'd1 || unf_err !== 1'b0) $display("[TB] FAIL pushpop_empty got %h/%0d/%b exp e4/1/0", flags_q, depth, unf_err); else passed++;
    endtask

    task automatic test_reset_mid();
        push = 1'b1;
        tick();
        push = 1'b1;
        tick();
        checks++; if (depth !== 3'd3) $display("[TB] FAIL mid_depth got %0d exp 3", depth); else passed++;
        rst = 1'b1; push = 1'b1;
        tick();
        checks++; if (depth !== 3'd0 || flags_q !== 8'h20 || ovf_err !== 1'b0 || empty !== 1'b1) $display("[TB] FAIL mid_reset got %0d/%h/%b/%b exp 0/20/0/1", depth, flags_q, ovf_err, empty); else passed++;
        pop = 1'b1;
        tick();
        checks++; if (unf_err !== 1'b1 || flags_q !== 8'h20 || depth !== 3'd0) $display("[TB] FAIL mid_unf got %b/%h/%0d exp 1/20/0", unf_err, flags_q, depth); else passed++;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_update_zn();
        test_push_pop();
        test_overflow();
        test_underflow_swap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
